// File: rtl/wave_pkg.sv
// Shared state encoding and sample-domain constants for the wave sequencer.
package wave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  localparam logic [1:0] Q1 = 2'b00;
  localparam logic [1:0] Q2 = 2'b01;
  localparam logic [1:0] Q3 = 2'b10;
  localparam logic [1:0] Q4 = 2'b11;

  localparam int unsigned      SAMPLE_W = 10;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 10'h200;

endpackage

// File: rtl/sample_tick_gen.sv
// Reloadable down-counter: ticks when enabled at zero, then reloads so the
// following tick lands i_reload+1 cycles later.
module sample_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_reload,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  // Load parks the counter at zero so the first enabled cycle ticks at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == '0) r_cnt <= i_reload;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/wave_sequencer.sv
// Phase-accumulator scheduler that walks a quarter-wave sine ROM and rebuilds
// a full-period offset-binary DAC stream under start/stop control.
module wave_sequencer
  import wave_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 9,
  parameter int PHASE_W = 16,
  parameter int DIV_W   = 16,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic               enable,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W:0]    sample,
  output logic               sample_valid,
  output logic [1:0]         quadrant,
  output logic               cycle_done,
  output logic [1:0]         o_dbg_state
);

  localparam logic [DATA_W:0] MID =
    (DATA_W + 1 == SAMPLE_W) ? (DATA_W+1)'(MIDSCALE) : {1'b1, {DATA_W{1'b0}}};

  seq_state_e         r_state;
  logic               r_cfg_ready;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_step;
  logic [DIV_W-1:0]   r_div;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_cycle_done;
  logic [ROM_LAT:0]   r_pipe_v;
  logic [1:0]         r_pipe_q [ROM_LAT+1];
  logic [DATA_W:0]    r_sample;
  logic               r_sample_valid;
  logic [1:0]         r_quadrant;

  logic               w_tick;
  logic               w_load;
  logic               w_cfg_fire;
  logic [1:0]         w_quad;
  logic [ADDR_W-1:0]  w_index;
  logic [ADDR_W-1:0]  w_mirror;
  logic [PHASE_W:0]   w_sum;
  logic [1:0]         w_out_q;

  // cfg_valid/cfg_ready: a transfer happens on a rising edge where both are
  // high; ready is high only in IDLE and the source holds valid until taken.
  assign w_cfg_fire = r_cfg_ready && cfg_valid;
  assign w_load     = (r_state == ST_IDLE) && enable;

  assign w_quad   = r_phase[PHASE_W-1 -: 2];
  assign w_index  = r_phase[PHASE_W-3 -: ADDR_W];
  assign w_mirror = (w_quad == Q2 || w_quad == Q4) ? ~w_index : w_index;
  assign w_sum    = {1'b0, r_phase} + {1'b0, r_step};
  assign w_out_q  = r_pipe_q[ROM_LAT];

  sample_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_en    (r_state == ST_RUN),
    .i_reload(r_div),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cfg_ready  <= 1'b1;
      r_phase      <= '0;
      r_step       <= '0;
      r_div        <= '0;
      r_rom_addr   <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_cycle_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cfg_fire) begin
            r_step  <= cfg_step;
            r_div   <= cfg_div;
            r_phase <= '0;
          end
          if (enable) begin
            r_state     <= ST_RUN;
            r_cfg_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          // A tick coinciding with the stop request is still issued.
          if (w_tick) begin
            r_rom_addr   <= w_mirror;
            r_phase      <= w_sum[PHASE_W-1:0];
            r_cycle_done <= w_sum[PHASE_W];
          end
          if (!enable) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_pipe_v == '0) begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // Quadrant travels alongside the ROM read so the sign matches the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_v <= '0;
      for (int i = 0; i <= ROM_LAT; i++) r_pipe_q[i] <= Q1;
      r_sample       <= MID;
      r_sample_valid <= 1'b0;
      r_quadrant     <= Q1;
    end else begin
      r_pipe_v[0] <= w_tick;
      r_pipe_q[0] <= w_quad;
      for (int i = 1; i <= ROM_LAT; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        r_pipe_q[i] <= r_pipe_q[i-1];
      end
      r_sample_valid <= r_pipe_v[ROM_LAT];
      if (r_pipe_v[ROM_LAT]) begin
        r_quadrant <= w_out_q;
        r_sample   <= (w_out_q == Q3 || w_out_q == Q4) ? {1'b0, ~rom_data}
                                                       : {1'b1, rom_data};
      end
    end
  end

  assign cfg_ready    = r_cfg_ready;
  assign rom_addr     = r_rom_addr;
  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign quadrant     = r_quadrant;
  assign cycle_done   = r_cycle_done;
  assign o_dbg_state  = r_state;

endmodule
